// File: rtl/fp16_add_arbiter.sv
// fp16_add_arbiter: round-robin sharing of one combinational FP16 adder among NUM_REQ valid/ready requesters
module fp16_adder (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] out
);
  logic        a_nan, b_nan, a_inf, b_inf, swap, sx, eff_sub;
  logic [14:0] x, y;
  logic [4:0]  ex, ey, d, lz, sh;
  logic [10:0] mx, my;
  logic [26:0] wide;
  logic [13:0] bm, sm, m;
  logic [14:0] n;
  logic [5:0]  e;
  logic [15:0] pre;
  logic        rnd;
  always_comb begin
    a_nan = &a[14:10] & |a[9:0];
    b_nan = &b[14:10] & |b[9:0];
    a_inf = &a[14:10] & ~|a[9:0];
    b_inf = &b[14:10] & ~|b[9:0];
    swap = b[14:0] > a[14:0];
    x = swap ? b[14:0] : a[14:0];
    y = swap ? a[14:0] : b[14:0];
    sx = swap ? b[15] : a[15];
    eff_sub = a[15] ^ b[15];
    ex = (x[14:10] == 5'd0) ? 5'd1 : x[14:10];
    ey = (y[14:10] == 5'd0) ? 5'd1 : y[14:10];
    mx = {|x[14:10], x[9:0]};
    my = {|y[14:10], y[9:0]};
    d = ex - ey;
    // Small operand aligned into mantissa + guard/round, everything lower folds into sticky
    wide = {my, 16'b0} >> ((d > 5'd16) ? 5'd16 : d);
    sm = {wide[26:14], |wide[13:0]};
    bm = {mx, 3'b000};
    n = eff_sub ? {1'b0, bm} - {1'b0, sm} : {1'b0, bm} + {1'b0, sm};
    lz = 5'd14;
    for (int i = 0; i < 14; i++)
      if (n[i]) lz = 5'(13 - i);
    // Normalisation never pushes the exponent below 1; anything left unnormalised is subnormal
    sh = (lz > ex - 5'd1) ? ex - 5'd1 : lz;
    m = n[14] ? {n[14:2], |n[1:0]} : n[13:0] << sh;
    e = n[14] ? {1'b0, ex} + 6'd1 : {1'b0, ex - sh};
    rnd = m[2] & (m[3] | m[1] | m[0]);
    pre = {(m[13] ? e : 6'd0), m[12:3]} + 16'(rnd);
    out = (a_nan | b_nan | (a_inf & b_inf & eff_sub)) ? 16'h7E00 :
          a_inf ? a :
          b_inf ? b :
          (n == 15'd0) ? {a[15] & b[15], 15'b0} :
          (pre[15:10] >= 6'd31) ? {sx, 15'h7C00} : {sx, pre[14:0]};
  end
endmodule

module fp16_add_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int CNT_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [16*NUM_REQ-1:0] req_a,
  input  logic [16*NUM_REQ-1:0] req_b,
  input  logic [NUM_REQ-1:0]    req_sub,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [15:0]           rsp_result,
  output logic [ID_W-1:0]       rsp_id,
  output logic [CNT_W-1:0]      ops_done
);
  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;
  state_t          state, state_nxt;
  logic [ID_W-1:0] rr_ptr, grant, idx, op_id;
  logic [ID_W:0]   cand;
  logic            found, accept;
  logic [15:0]     op_a, op_b, sum;
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx = '0;
    cand = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (ID_W+1)'(k);
      idx = (cand >= (ID_W+1)'(NUM_REQ)) ? ID_W'(cand - (ID_W+1)'(NUM_REQ)) : cand[ID_W-1:0];
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end
  assign accept = (state == IDLE) && found;
  assign req_ready = accept ? NUM_REQ'(1) << grant : '0;
  always_comb begin
    state_nxt = (state == IDLE) ? (found ? CALC : IDLE) :
                (state == CALC) ? RESP :
                (rsp_ready ? IDLE : RESP);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  end
  fp16_adder u_add (.a(op_a), .b(op_b), .out(sum));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      op_a <= '0;
      op_b <= '0;
      op_id <= '0;
      rsp_valid <= 1'b0;
      rsp_result <= '0;
      rsp_id <= '0;
      ops_done <= '0;
    end else begin
      if (accept) begin
        op_a <= req_a[{grant, 4'b0} +: 16];
        op_b <= req_b[{grant, 4'b0} +: 16] ^ {req_sub[grant], 15'b0};
        op_id <= grant;
        rr_ptr <= (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
      end
      if (state == CALC) begin
        rsp_result <= sum;
        rsp_id <= op_id;
        rsp_valid <= 1'b1;
      end
      if (rsp_valid && rsp_ready) begin
        rsp_valid <= 1'b0;
        ops_done <= ops_done + CNT_W'(1);
      end
    end
  end
endmodule
